mobo_bus: RTL and testbench
===========================

# mobo_bus

Motherboard bus controller sitting directly downstream of `cpu`. It consumes the CPU's `mobo_ctrl`, `addr` and `data_out` and returns `mobo_stat` and `data_in`. It decodes each request to on-board RAM or the write-only VGA framebuffer and runs the access with wait states. It reports completion, busy and error back to the CPU.

## Interface
Parameters:
- `word_width`, 32, width of address and data words.
- `ram_words`, 4096, RAM size in words; RAM occupies addresses 0 .. ram_words-1.
- `vga_base`, 32'h0001_0000, first framebuffer address.
- `vga_words`, 4800, framebuffer size in words.
- `vga_timeout`, 1024, maximum cycles a VGA write waits for `vga_ready`.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  reset; synchronous and active-high.
- `mobo_ctrl`  in  word_width  bit0 req, bit1 we; other bits ignored.
- `mobo_stat`  out  word_width  bit0 done, bit1 busy, bit2 err; other bits 0.
- `addr`  in  word_width  CPU word address.
- `data_out`  in  word_width  CPU write data.
- `data_in`  out  word_width  read data returned to the CPU.
- `ram_addr`  out  word_width  RAM word address.
- `ram_re`  out  1  RAM read strobe.
- `ram_we`  out  1  RAM write strobe.
- `ram_wdata`  out  word_width  RAM write data.
- `ram_rdata`  in  word_width  RAM read data, valid 1 cycle after `ram_re`.
- `vga_addr`  out  word_width  framebuffer offset (addr - vga_base).
- `vga_we`  out  1  framebuffer write strobe.
- `vga_wdata`  out  word_width  framebuffer write data.
- `vga_ready`  in  1  framebuffer accepts a write this cycle.

## Operation
- States: IDLE, RAM_RD, RAM_CAP, RAM_WR, VGA_WR, DONE, ERR, REL.
- IDLE: if req=1, latch addr, we and data_out, set busy, then decode.
  - RAM hit with we=1 → RAM_WR.
  - RAM hit with we=0 → RAM_RD.
  - VGA hit with we=1 → VGA_WR.
  - VGA hit with we=0, or unmapped address → ERR.
- Decode rules: RAM hit when addr < ram_words. VGA hit when vga_base ≤ addr < vga_base+vga_words. Compare unsigned at full width; no wrap.
- RAM_WR: ram_we=1 for one cycle with latched addr/data → DONE.
- RAM_RD: ram_re=1 for one cycle → RAM_CAP.
- RAM_CAP: register ram_rdata into data_in → DONE.
- VGA_WR: hold vga_we=1 with latched vga_addr/vga_wdata until vga_ready=1 (the write happens in that cycle) → DONE.
  - Cycle counter from 0; if it reaches vga_timeout-1 with vga_ready still 0 → ERR, and no write occurs.
- DONE: done=1 for exactly one cycle → REL.
- ERR: done=1 and err=1 for exactly one cycle → REL. data_in is unchanged.
- REL: busy stays 1 until req=0, then → IDLE with busy=0. A request left high is never executed twice.
- data_in holds the last successful read until the next one completes.
- Strobes (`ram_re`, `ram_we`, `vga_we`) are 0 in every state not listed above.

## Timing
- Reset: state IDLE. mobo_stat, data_in, ram_addr, ram_re, ram_we, ram_wdata, vga_addr, vga_we, vga_wdata all 0. Timeout counter 0.
- Reset mid-transfer aborts the access at the next posedge: strobes drop and no done pulse is issued.
- Request seen at edge T (IDLE):
  - RAM write: ram_we in cycle T+1, done in T+2.
  - RAM read: ram_re in T+1, data captured at end of T+2, done in T+3 with data_in valid.
  - VGA write with vga_ready already 1: vga_we in T+1, done in T+2. Each low cycle of vga_ready adds one cycle.
  - Error: done+err in T+1.
- CPU rule: hold addr/data_out/ctrl stable while busy. Inputs are sampled only in IDLE.
- Minimum spacing between two accesses is 2 cycles after done (REL with req low, then IDLE).

## Structure
- Shared include `verilog_src/mobo_defs.v`, in the same style as `cpu_states.v`:
  - state codes;
  - ctrl/stat bit positions;
  - default address-map constants.
- Single module; decode comparators and the timeout counter are inline. No sub-module.

## Test plan
- RAM write 0x10 ← 0xDEADBEEF, then read 0x10: ram_we at T+1, done at T+2; the read gives done at T+3 with data_in=0xDEADBEEF.
- VGA write at vga_base+5 with vga_ready held low 3 cycles: vga_we held, vga_addr=5, single write when ready rises, done 1 cycle later.
- VGA write with vga_ready stuck 0: err+done exactly vga_timeout cycles after vga_we first asserted, and no write accepted.
- Read vga_base, and access 0x8000_0000: each gives err+done at T+1, no strobes, data_in unchanged.
- req held high for 10 cycles after done: exactly one RAM access and busy=1 until req drops. Also assert rst during RAM_RD: no done pulse, all outputs 0 next cycle.

Source files
------------

// File: rtl/mobo_bus_pkg.sv
// Shared definitions for the motherboard bus controller: FSM state codes,
// CPU ctrl/stat bit positions and the default address map.
// No ports; imported by mobo_bus.
package mobo_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RAM_RD  = 3'd1,
      S_RAM_CAP = 3'd2,
      S_RAM_WR  = 3'd3,
      S_VGA_WR  = 3'd4,
      S_DONE    = 3'd5,
      S_ERR     = 3'd6,
      S_REL     = 3'd7
   } state_e;

   // Bit positions inside mobo_ctrl / mobo_stat
   localparam int CTRL_REQ  = 0;
   localparam int CTRL_WE   = 1;
   localparam int STAT_DONE = 0;
   localparam int STAT_BUSY = 1;
   localparam int STAT_ERR  = 2;

   // Default address map
   localparam int unsigned RAM_WORDS_DEF   = 4096;
   localparam int unsigned VGA_BASE_DEF    = 32'h0001_0000;
   localparam int unsigned VGA_WORDS_DEF   = 4800;
   localparam int unsigned VGA_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/mobo_bus.sv
// Motherboard bus controller: decodes CPU requests to on-board RAM or the
// write-only VGA framebuffer and runs each access with wait states.
// Latency: RAM wr done at T+2, RAM rd done at T+3, VGA wr done one cycle after
// vga_ready, decode error done+err at T+1. Backpressure: vga_ready stalls VGA
// writes up to vga_timeout cycles; the CPU is held off via busy until req drops.
// Ports: clk/rst; CPU side mobo_ctrl, mobo_stat, addr, data_out, data_in;
// RAM side ram_addr/ram_re/ram_we/ram_wdata/ram_rdata; VGA side
// vga_addr/vga_we/vga_wdata/vga_ready.
module mobo_bus
   import mobo_bus_pkg::*;
#(
   parameter int          word_width  = 32,
   parameter int unsigned ram_words   = RAM_WORDS_DEF,
   parameter int unsigned vga_base    = VGA_BASE_DEF,
   parameter int unsigned vga_words   = VGA_WORDS_DEF,
   parameter int unsigned vga_timeout = VGA_TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [word_width-1:0] mobo_ctrl,
   output logic [word_width-1:0] mobo_stat,
   input  logic [word_width-1:0] addr,
   input  logic [word_width-1:0] data_out,
   output logic [word_width-1:0] data_in,
   output logic [word_width-1:0] ram_addr,
   output logic                  ram_re,
   output logic                  ram_we,
   output logic [word_width-1:0] ram_wdata,
   input  logic [word_width-1:0] ram_rdata,
   output logic [word_width-1:0] vga_addr,
   output logic                  vga_we,
   output logic [word_width-1:0] vga_wdata,
   input  logic                  vga_ready
);

   localparam int CW = $clog2(vga_timeout + 1);

   // Address map bounds carried one bit wider so vga_base+vga_words cannot wrap
   localparam logic [word_width:0]   RAM_LIM    = (word_width+1)'(ram_words);
   localparam logic [word_width:0]   VGA_LO     = (word_width+1)'(vga_base);
   localparam logic [word_width:0]   VGA_HI     = VGA_LO + (word_width+1)'(vga_words);
   localparam logic [word_width-1:0] VGA_BASE_W = VGA_LO[word_width-1:0];
   localparam logic [CW-1:0]         CNT_LAST   = CW'(vga_timeout - 1);

   state_e                  state_q;
   logic                    done_q, busy_q, err_q;
   logic                    ram_re_q, ram_we_q, vga_we_q;
   logic [word_width-1:0]   data_in_q, ram_addr_q, ram_wdata_q, vga_addr_q, vga_wdata_q;
   logic [CW-1:0]           cnt_q;

   logic [word_width:0]     addr_x;
   logic                    ram_hit, vga_hit, req, we;
   logic                    unused_ctrl;

   assign addr_x      = {1'b0, addr};
   assign ram_hit     = addr_x < RAM_LIM;
   assign vga_hit     = (addr_x >= VGA_LO) && (addr_x < VGA_HI);
   assign req         = mobo_ctrl[CTRL_REQ];
   assign we          = mobo_ctrl[CTRL_WE];
   assign unused_ctrl = ^mobo_ctrl[word_width-1:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         ram_re_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         vga_we_q    <= 1'b0;
         data_in_q   <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         vga_addr_q  <= '0;
         vga_wdata_q <= '0;
         cnt_q       <= '0;
      end else begin
         // Strobes and status pulses are single-cycle unless re-armed below
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         ram_re_q <= 1'b0;
         ram_we_q <= 1'b0;
         vga_we_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (req) begin
                  busy_q <= 1'b1;
                  if (ram_hit) begin
                     ram_addr_q <= addr;
                     if (we) begin
                        ram_wdata_q <= data_out;
                        ram_we_q    <= 1'b1;
                        state_q     <= S_RAM_WR;
                     end else begin
                        ram_re_q <= 1'b1;
                        state_q  <= S_RAM_RD;
                     end
                  end else if (vga_hit && we) begin
                     vga_addr_q  <= addr - VGA_BASE_W;
                     vga_wdata_q <= data_out;
                     vga_we_q    <= 1'b1;
                     cnt_q       <= '0;
                     state_q     <= S_VGA_WR;
                  end else begin
                     // Framebuffer reads and unmapped addresses fail immediately
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end
               end
            end
            S_RAM_WR: begin
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_RAM_RD: state_q <= S_RAM_CAP;
            S_RAM_CAP: begin
               data_in_q <= ram_rdata;
               done_q    <= 1'b1;
               state_q   <= S_DONE;
            end
            S_VGA_WR: begin
               if (vga_ready) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (cnt_q == CNT_LAST) begin
                  // Give up: vga_we drops without the write being accepted
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  state_q <= S_ERR;
               end else begin
                  vga_we_q <= 1'b1;
                  cnt_q    <= cnt_q + CW'(1);
               end
            end
            S_DONE, S_ERR: state_q <= S_REL;
            S_REL: begin
               // Wait for req to drop so a held request is not replayed
               if (!req) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      mobo_stat            = '0;
      mobo_stat[STAT_DONE] = done_q;
      mobo_stat[STAT_BUSY] = busy_q;
      mobo_stat[STAT_ERR]  = err_q;
   end

   assign data_in   = data_in_q;
   assign ram_addr  = ram_addr_q;
   assign ram_re    = ram_re_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = ram_wdata_q;
   assign vga_addr  = vga_addr_q;
   assign vga_we    = vga_we_q;
   assign vga_wdata = vga_wdata_q;

endmodule

// File: tb/tb_mobo_bus.sv
// Testbench for mobo_bus: table of single accesses with expected latency,
// status, strobe counts and data, plus a reset-during-read sequence.
// Ports driven on negedge, outputs sampled on negedge.
module tb_mobo_bus;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mobo_ctrl, mobo_stat, addr, data_out, data_in;
   logic [31:0] ram_addr, ram_wdata, ram_rdata, vga_addr, vga_wdata;
   logic        ram_re, ram_we, vga_we, vga_ready;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mobo_bus dut (
      .clk       (clk),
      .rst       (rst),
      .mobo_ctrl (mobo_ctrl),
      .mobo_stat (mobo_stat),
      .addr      (addr),
      .data_out  (data_out),
      .data_in   (data_in),
      .ram_addr  (ram_addr),
      .ram_re    (ram_re),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .vga_addr  (vga_addr),
      .vga_we    (vga_we),
      .vga_wdata (vga_wdata),
      .vga_ready (vga_ready)
   );

   // Behavioural RAM: read data one cycle after ram_re
   logic [31:0] mem [logic [31:0]];
   initial ram_rdata = 32'h0;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] = ram_wdata;
      if (ram_re) ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // chk: 0 no address check, 1 check ram_addr, 2 check vga_addr/vga_wdata
   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      int          lo;     // cycles vga_ready held low after request
      int          hold;   // extra cycles req stays high after done
      int          lat;    // cycle index of done (1 = cycle after request edge)
      logic        err;
      int          n_rwe;
      int          n_rre;
      int          n_vwr;
      int          chk;
      logic [31:0] aout;
      logic [31:0] din;
   } vec_t;

   task automatic run_vec(input int idx, input vec_t v);
      int k = 0, n_rwe = 0, n_rre = 0, n_vwr = 0;
      logic [31:0] ra = 32'hFFFF_FFFF, va = 32'hFFFF_FFFF, vd = 32'hFFFF_FFFF;
      logic vseen = 1'b0, got_done = 1'b0, got_err = 1'b0;
      string tag;
      tag = $sformatf("v%0d", idx);
      mobo_ctrl = {30'b0, v.we, 1'b1};
      addr      = v.a;
      data_out  = v.wd;
      while (!got_done && k < 1500) begin
         @(negedge clk);
         k++;
         vga_ready = (k > v.lo);
         if (ram_we) begin n_rwe++; ra = ram_addr; end
         if (ram_re) begin n_rre++; ra = ram_addr; end
         if (vga_we && !vseen) begin va = vga_addr; vd = vga_wdata; vseen = 1'b1; end
         if (vga_we && vga_ready) n_vwr++;
         if (mobo_stat[0]) begin got_done = 1'b1; got_err = mobo_stat[2]; end
      end
      vga_ready = 1'b0;
      check({tag, "_done_seen"}, 32'(got_done), 32'd1);
      check({tag, "_latency"},   32'(k), 32'(v.lat));
      check({tag, "_err"},       32'(got_err), 32'(v.err));
      check({tag, "_ram_we_n"},  32'(n_rwe), 32'(v.n_rwe));
      check({tag, "_ram_re_n"},  32'(n_rre), 32'(v.n_rre));
      check({tag, "_vga_wr_n"},  32'(n_vwr), 32'(v.n_vwr));
      check({tag, "_data_in"},   data_in, v.din);
      if (v.chk == 1) check({tag, "_ram_addr"}, ra, v.aout);
      if (v.chk == 2) begin
         check({tag, "_vga_addr"},  va, v.aout);
         check({tag, "_vga_wdata"}, vd, v.wd);
      end
      for (int h = 0; h <= v.hold; h++) begin
         @(negedge clk);
         check({tag, "_rel_stat"}, mobo_stat, 32'h2);
         check({tag, "_rel_strobes"}, {29'b0, ram_re, ram_we, vga_we}, 32'h0);
      end
      mobo_ctrl = 32'h0;
      @(negedge clk);
      check({tag, "_idle_stat"}, mobo_stat, 32'h0);
   endtask

   vec_t vecs[15];

   initial begin
      //          we    addr           wdata          lo    hold lat  err  rwe rre vwr chk aout          din
      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0,    0,   2,   1'b0, 1, 0, 0, 1, 32'h0000_0010, 32'h0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         0,    0,   3,   1'b0, 0, 1, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 32'h0000_0FFF, 32'h1234_5678, 0,    0,   2,   1'b0, 1, 0, 0, 1, 32'h0000_0FFF, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b0, 32'h0000_0FFF, 32'h0,         0,    0,   3,   1'b0, 0, 1, 0, 1, 32'h0000_0FFF, 32'h1234_5678};
      vecs[4]  = '{1'b0, 32'h0000_1000, 32'h0,         0,    0,   1,   1'b1, 0, 0, 0, 0, 32'h0,         32'h1234_5678};
      vecs[5]  = '{1'b1, 32'h0001_0005, 32'hCAFE_0005, 3,    0,   5,   1'b0, 0, 0, 1, 2, 32'h0000_0005, 32'h1234_5678};
      vecs[6]  = '{1'b1, 32'h0001_0000, 32'h0BAD_F00D, 0,    0,   2,   1'b0, 0, 0, 1, 2, 32'h0000_0000, 32'h1234_5678};
      vecs[7]  = '{1'b1, 32'h0001_12BF, 32'h5555_AAAA, 0,    0,   2,   1'b0, 0, 0, 1, 2, 32'h0000_12BF, 32'h1234_5678};
      vecs[8]  = '{1'b1, 32'h0001_12C0, 32'h1,         0,    0,   1,   1'b1, 0, 0, 0, 0, 32'h0,         32'h1234_5678};
      vecs[9]  = '{1'b0, 32'h0001_0000, 32'h0,         0,    0,   1,   1'b1, 0, 0, 0, 0, 32'h0,         32'h1234_5678};
      vecs[10] = '{1'b0, 32'h8000_0000, 32'h0,         0,    0,   1,   1'b1, 0, 0, 0, 0, 32'h0,         32'h1234_5678};
      vecs[11] = '{1'b1, 32'h8000_0000, 32'h7,         0,    0,   1,   1'b1, 0, 0, 0, 0, 32'h0,         32'h1234_5678};
      vecs[12] = '{1'b1, 32'h0001_0005, 32'hFEED_FACE, 2000, 0,   1025,1'b1, 0, 0, 0, 2, 32'h0000_0005, 32'h1234_5678};
      vecs[13] = '{1'b1, 32'h0000_0020, 32'h0000_A5A5, 0,    10,  2,   1'b0, 1, 0, 0, 1, 32'h0000_0020, 32'h1234_5678};
      vecs[14] = '{1'b0, 32'h0000_0020, 32'h0,         0,    10,  3,   1'b0, 0, 1, 0, 1, 32'h0000_0020, 32'h0000_A5A5};

      rst = 1'b1; mobo_ctrl = 32'h0; addr = 32'h0; data_out = 32'h0; vga_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_stat",     mobo_stat, 32'h0);
      check("rst_data_in",  data_in,   32'h0);
      check("rst_ram_addr", ram_addr,  32'h0);
      check("rst_strobes",  {29'b0, ram_re, ram_we, vga_we}, 32'h0);
      check("rst_wdata",    ram_wdata | vga_wdata | vga_addr, 32'h0);

      for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

      // Reset while RAM_RD: access aborted, everything cleared, no done pulse
      mobo_ctrl = 32'h1;
      addr      = 32'h0000_0020;
      @(negedge clk);
      check("abort_re_before", {31'b0, ram_re}, 32'h1);
      check("abort_busy_before", mobo_stat, 32'h2);
      rst = 1'b1;
      mobo_ctrl = 32'h0;
      @(negedge clk);
      check("abort_stat",    mobo_stat, 32'h0);
      check("abort_data_in", data_in,   32'h0);
      check("abort_strobes", {29'b0, ram_re, ram_we, vga_we}, 32'h0);
      check("abort_regs",    ram_addr | ram_wdata | vga_addr | vga_wdata, 32'h0);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("abort_no_done", mobo_stat, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
